// File: rtl/cic_decimator_mc.sv
// Multi-channel CIC decimator: NUM_CH lanes share one decimation counter.
// The decimation ratio and output shift are set at runtime. The output saturates
// and uses a valid/ready handshake.
// Ports: clk, arst_n (async, active low), clear (sync flush),
//   dec_ratio (ratio R; 0 -> 1, clamped to MAX_DECIMATION), shift (arith right),
//   data_in/data_in_valid (packed, ch0 in LSBs, always accepted),
//   data_out/data_out_valid/data_out_ready (packed, ch0 in LSBs),
//   overflow (sticky; set when a decimated sample is dropped).
// Define CIC_ROUND_EN to round half up before the shift; otherwise the shift truncates.
module cic_decimator_mc #(
    parameter int DATA_WIDTH     = 12,
    parameter int OUT_WIDTH      = 16,
    parameter int NUM_CH         = 2,
    parameter int N_STAGES       = 3,
    parameter int DDELAY         = 1,
    parameter int MAX_DECIMATION = 64,
    localparam int CW    = $clog2(MAX_DECIMATION + 1),
    localparam int REG_W = DATA_WIDTH + N_STAGES * $clog2(MAX_DECIMATION * DDELAY),
    localparam int SH_W  = $clog2(REG_W)
) (
    input  logic                         clk,
    input  logic                         arst_n,
    input  logic                         clear,
    input  logic [CW-1:0]                dec_ratio,
    input  logic [SH_W-1:0]              shift,
    input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
    input  logic                         data_in_valid,
    output logic [NUM_CH*OUT_WIDTH-1:0]  data_out,
    output logic                         data_out_valid,
    input  logic                         data_out_ready,
    output logic                         overflow
);

    localparam logic signed [REG_W:0] SAT_HI = (REG_W+1)'((1 <<< (OUT_WIDTH - 1)) - 1);
    localparam logic signed [REG_W:0] SAT_LO = ~SAT_HI;
`ifdef CIC_ROUND_EN
    localparam logic signed [REG_W:0] ONE = (REG_W+1)'(1);
`endif

    logic [CW-1:0] r_act, r_new, r_eff, cnt;
    logic          pending, comb_en, out_ld, wrap;

    logic signed [REG_W-1:0] integ [NUM_CH][N_STAGES];
    logic signed [REG_W-1:0] comb  [NUM_CH][N_STAGES];
    logic signed [REG_W-1:0] dly   [NUM_CH][N_STAGES][DDELAY];
    logic signed [REG_W-1:0] x_ext [NUM_CH];
    logic signed [REG_W-1:0] c_in  [NUM_CH][N_STAGES];
    logic [NUM_CH*OUT_WIDTH-1:0] y_pk;

    always_comb begin
        if (dec_ratio == '0)
            r_new = CW'(1);
        else if (dec_ratio > CW'(MAX_DECIMATION))
            r_new = CW'(MAX_DECIMATION);
        else
            r_new = dec_ratio;
    end

    // Right after reset or clear, the ratio comes straight from the port.
    assign r_eff = pending ? r_new : r_act;
    assign wrap  = data_in_valid && (cnt == r_eff - CW'(1));

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt     <= '0;
            r_act   <= CW'(1);
            pending <= 1'b1;
            comb_en <= 1'b0;
            out_ld  <= 1'b0;
        end else if (clear) begin
            cnt     <= '0;
            r_act   <= CW'(1);
            pending <= 1'b1;
            comb_en <= 1'b0;
            out_ld  <= 1'b0;
        end else begin
            pending <= 1'b0;
            comb_en <= wrap;
            out_ld  <= comb_en;
            if (pending)
                r_act <= r_new;
            if (wrap) begin
                cnt   <= '0;
                r_act <= r_new;
            end else if (data_in_valid) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    always_comb begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
            x_ext[ch]   = REG_W'(signed'(data_in[ch*DATA_WIDTH +: DATA_WIDTH]));
            c_in[ch][0] = integ[ch][N_STAGES-1];
            for (int s = 1; s < N_STAGES; s++)
                c_in[ch][s] = comb[ch][s-1];
        end
    end

    // Each integrator stage is registered. Wraparound at REG_W bits is harmless.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int ch = 0; ch < NUM_CH; ch++)
                for (int s = 0; s < N_STAGES; s++)
                    integ[ch][s] <= '0;
        end else if (clear) begin
            for (int ch = 0; ch < NUM_CH; ch++)
                for (int s = 0; s < N_STAGES; s++)
                    integ[ch][s] <= '0;
        end else if (data_in_valid) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                integ[ch][0] <= integ[ch][0] + x_ext[ch];
                for (int s = 1; s < N_STAGES; s++)
                    integ[ch][s] <= integ[ch][s] + integ[ch][s-1];
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int ch = 0; ch < NUM_CH; ch++)
                for (int s = 0; s < N_STAGES; s++) begin
                    comb[ch][s] <= '0;
                    for (int d = 0; d < DDELAY; d++)
                        dly[ch][s][d] <= '0;
                end
        end else if (clear) begin
            for (int ch = 0; ch < NUM_CH; ch++)
                for (int s = 0; s < N_STAGES; s++) begin
                    comb[ch][s] <= '0;
                    for (int d = 0; d < DDELAY; d++)
                        dly[ch][s][d] <= '0;
                end
        end else if (comb_en) begin
            for (int ch = 0; ch < NUM_CH; ch++)
                for (int s = 0; s < N_STAGES; s++) begin
                    comb[ch][s]   <= c_in[ch][s] - dly[ch][s][DDELAY-1];
                    dly[ch][s][0] <= c_in[ch][s];
                    for (int d = 1; d < DDELAY; d++)
                        dly[ch][s][d] <= dly[ch][s][d-1];
                end
        end
    end

    // One guard bit keeps the rounding add from wrapping.
    always_comb begin : scale
        logic signed [REG_W:0] wide;
        logic signed [REG_W:0] shd;
        y_pk = '0;
        wide = '0;
        shd  = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            wide = {comb[ch][N_STAGES-1][REG_W-1], comb[ch][N_STAGES-1]};
`ifdef CIC_ROUND_EN
            if (shift != '0)
                wide = wide + (ONE << (shift - 1'b1));
`endif
            shd = wide >>> shift;
            if (int'(shift) >= REG_W)
                shd = {(REG_W+1){comb[ch][N_STAGES-1][REG_W-1]}};
            if (shd > SAT_HI)
                y_pk[ch*OUT_WIDTH +: OUT_WIDTH] = OUT_WIDTH'(SAT_HI);
            else if (shd < SAT_LO)
                y_pk[ch*OUT_WIDTH +: OUT_WIDTH] = OUT_WIDTH'(SAT_LO);
            else
                y_pk[ch*OUT_WIDTH +: OUT_WIDTH] = OUT_WIDTH'(shd);
        end
    end

    // A sample that arrives while an unaccepted one is still held is dropped.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            data_out       <= '0;
            data_out_valid <= 1'b0;
            overflow       <= 1'b0;
        end else if (clear) begin
            data_out       <= '0;
            data_out_valid <= 1'b0;
            overflow       <= 1'b0;
        end else if (out_ld) begin
            if (data_out_valid && !data_out_ready) begin
                overflow <= 1'b1;
            end else begin
                data_out       <= y_pk;
                data_out_valid <= 1'b1;
            end
        end else if (data_out_valid && data_out_ready) begin
            data_out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cic_decimator_mc.sv
// Testbench for cic_decimator_mc. It compares the DUT against a reference model
// that computes the CIC response as weighted sums of the input samples.
module tb_cic_decimator_mc;

    localparam int DW    = 12;
    localparam int OW    = 16;
    localparam int NCH   = 2;
    localparam int MAXD  = 64;
    localparam int CW    = $clog2(MAXD + 1);
    localparam int REG_W = DW + 3 * $clog2(MAXD);
    localparam int SH_W  = $clog2(REG_W);

    logic                  clk = 1'b0;
    logic                  arst_n;
    logic                  clear;
    logic [CW-1:0]         dec_ratio;
    logic [SH_W-1:0]       shift;
    logic [NCH*DW-1:0]     data_in;
    logic                  data_in_valid;
    logic [NCH*OW-1:0]     data_out;
    logic                  data_out_valid;
    logic                  data_out_ready;
    logic                  overflow;

    cic_decimator_mc dut (
        .clk(clk), .arst_n(arst_n), .clear(clear),
        .dec_ratio(dec_ratio), .shift(shift),
        .data_in(data_in), .data_in_valid(data_in_valid),
        .data_out(data_out), .data_out_valid(data_out_valid),
        .data_out_ready(data_out_ready), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    longint xs0[$], xs1[$];
    longint s0[$], s1[$];
    int     due_q[$];
    longint c0_q[$], c1_q[$];
    int     cnt_m, r_act_m, t;
    bit     pend_m, ev_m, ov_m;
    longint ed0, ed1, last0, last1;

    task automatic chk(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
        checks++;
        assert (got === exp) passes++;
        else $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic logic signed [63:0] dout(input int ch);
        return 64'(signed'(data_out[ch*OW +: OW]));
    endfunction

    function automatic int clampr(input int d);
        if (d == 0) return 1;
        if (d > MAXD) return MAXD;
        return d;
    endfunction

    // Output of the three pipelined integrators after the latest input n:
    // sum over k of x[k] * C(n-k, 2).
    function automatic longint integ3(input int ch);
        longint acc, w, xv;
        int n;
        acc = 0;
        n = (ch == 0) ? xs0.size() - 1 : xs1.size() - 1;
        for (int k = 0; k <= n; k++) begin
            w  = longint'(n - k) * longint'(n - k - 1) / 2;
            xv = (ch == 0) ? xs0[k] : xs1[k];
            acc += xv * w;
        end
        return acc;
    endfunction

    function automatic longint sg(input int ch, input int idx);
        if (idx < 0) return 0;
        return (ch == 0) ? s0[idx] : s1[idx];
    endfunction

    function automatic longint wrapr(input longint v);
        longint m;
        m = v & ((longint'(1) <<< REG_W) - 1);
        if (m >= (longint'(1) <<< (REG_W - 1)))
            m -= longint'(1) <<< REG_W;
        return m;
    endfunction

    function automatic longint outv(input longint c);
        longint v, hi, lo;
        int sh;
        sh = int'(shift);
        c  = wrapr(c);
        if (sh >= REG_W) begin
            v = (c < 0) ? -1 : 0;
        end else begin
`ifdef CIC_ROUND_EN
            if (sh > 0) c += longint'(1) <<< (sh - 1);
`endif
            v = c >>> sh;
        end
        hi = (longint'(1) <<< (OW - 1)) - 1;
        lo = -(longint'(1) <<< (OW - 1));
        if (v > hi) v = hi;
        if (v < lo) v = lo;
        return v;
    endfunction

    task automatic model_reset();
        xs0.delete(); xs1.delete(); s0.delete(); s1.delete();
        due_q.delete(); c0_q.delete(); c1_q.delete();
        cnt_m = 0; r_act_m = 1; pend_m = 1;
        ev_m = 0; ov_m = 0; ed0 = 0; ed1 = 0;
    endtask

    // Applies one rising edge to the reference model.
    task automatic model_edge(input bit v, input int x0, input int x1,
                              input bit rdy, input bit clr);
        int r_use, m;
        longint c0, c1;
        if (clr) begin
            model_reset();
        end else begin
            if (due_q.size() != 0 && due_q[0] == t) begin
                void'(due_q.pop_front());
                c0 = c0_q.pop_front();
                c1 = c1_q.pop_front();
                if (ev_m && !rdy) begin
                    ov_m = 1;
                end else begin
                    ev_m = 1;
                    ed0 = outv(c0);
                    ed1 = outv(c1);
                end
            end else if (ev_m && rdy) begin
                ev_m = 0;
            end
            r_use = pend_m ? clampr(int'(dec_ratio)) : r_act_m;
            if (pend_m) r_act_m = r_use;
            pend_m = 0;
            if (v) begin
                xs0.push_back(longint'(x0));
                xs1.push_back(longint'(x1));
                cnt_m++;
                if (cnt_m == r_use) begin
                    cnt_m = 0;
                    r_act_m = clampr(int'(dec_ratio));
                    s0.push_back(integ3(0));
                    s1.push_back(integ3(1));
                    m = s0.size() - 1;
                    c0 = sg(0, m-2) - 3*sg(0, m-3) + 3*sg(0, m-4) - sg(0, m-5);
                    c1 = sg(1, m-2) - 3*sg(1, m-3) + 3*sg(1, m-4) - sg(1, m-5);
                    due_q.push_back(t + 2);
                    c0_q.push_back(c0);
                    c1_q.push_back(c1);
                end
            end
        end
        t++;
    endtask

    task automatic cyc(input bit v, input int x0, input int x1,
                       input bit rdy, input bit clr);
        data_in_valid  = v;
        data_in        = {DW'(x1), DW'(x0)};
        data_out_ready = rdy;
        clear          = clr;
        @(posedge clk);
        model_edge(v, x0, x1, rdy, clr);
        #1;
        chk("valid", 64'(data_out_valid), 64'(ev_m));
        chk("overflow", 64'(overflow), 64'(ov_m));
        if (ev_m) begin
            chk("ch0", dout(0), ed0);
            chk("ch1", dout(1), ed1);
        end
        if (data_out_valid) begin
            last0 = dout(0);
            last1 = dout(1);
        end
    endtask

    function automatic int rnd();
        return int'($urandom_range(0, 4095)) - 2048;
    endfunction

    task automatic do_async_reset();
        arst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_valid", 64'(data_out_valid), 0);
        chk("rst_ovf", 64'(overflow), 0);
        chk("rst_data", 64'(data_out), 0);
        @(negedge clk);
        arst_n = 1'b1;
    endtask

    initial begin
        t = 0;
        last0 = 0;
        last1 = 0;
        clear = 0;
        data_in_valid = 0;
        data_in = '0;
        data_out_ready = 1;
        dec_ratio = CW'(4);
        shift = '0;
        arst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_valid", 64'(data_out_valid), 0);
        chk("rst_ovf", 64'(overflow), 0);
        chk("rst_data", 64'(data_out), 0);
        @(negedge clk);
        arst_n = 1'b1;

        for (int i = 0; i < 48; i++) cyc(1, 100, 100, 1, 0);
        chk("dc100_ch0", last0, 6400);
        chk("dc100_ch1", last1, 6400);

        dec_ratio = CW'(5);
        shift = SH_W'(3);
        for (int i = 0; i < 200; i++)
            cyc($urandom_range(0, 3) != 0, rnd(), rnd(), 1, 0);

        dec_ratio = CW'(1);
        shift = '0;
        cyc(0, 0, 0, 1, 1);
        cyc(1, 1, 0, 1, 0);
        for (int i = 0; i < 12; i++) cyc(1, 0, 0, 1, 0);
        chk("impulse_tail", last0, 0);

        dec_ratio = CW'(64);
        cyc(0, 0, 0, 1, 1);
        for (int i = 0; i < 448; i++) cyc(1, 2047, 2047, 1, 0);
        chk("sat_hi", last0, 32767);
        cyc(0, 0, 0, 1, 1);
        for (int i = 0; i < 448; i++) cyc(1, -2048, -2048, 1, 0);
        chk("sat_lo", last1, -32768);

        dec_ratio = CW'(2);
        shift = SH_W'(4);
        cyc(0, 0, 0, 1, 1);
        for (int i = 0; i < 24; i++) cyc(1, 3, 3, 1, 0);
`ifdef CIC_ROUND_EN
        chk("shift4_round", last0, 2);
`else
        chk("shift4_trunc", last0, 1);
`endif

        dec_ratio = CW'(4);
        shift = '0;
        cyc(0, 0, 0, 1, 1);
        for (int i = 0; i < 12; i++) cyc(1, 50, -50, 1, 0);
        for (int i = 0; i < 10; i++) cyc(1, 50, -50, 0, 0);
        chk("ovf_sticky", 64'(overflow), 1);
        for (int i = 0; i < 6; i++) cyc(1, 50, -50, 1, 0);

        cyc(0, 0, 0, 1, 1);
        cyc(1, rnd(), rnd(), 1, 0);
        cyc(1, rnd(), rnd(), 1, 0);
        dec_ratio = CW'(8);
        for (int i = 0; i < 60; i++) cyc(1, rnd(), rnd(), 1, 0);

        dec_ratio = CW'(3);
        shift = SH_W'(2);
        for (int i = 0; i < 150; i++)
            cyc($urandom_range(0, 1), rnd(), rnd(), $urandom_range(0, 1), 0);

        shift = SH_W'(31);
        for (int i = 0; i < 40; i++) cyc(1, rnd(), rnd(), 1, 0);
        shift = SH_W'(30);
        for (int i = 0; i < 40; i++) cyc(1, rnd(), rnd(), 1, 0);

        shift = SH_W'(12);
        dec_ratio = CW'(0);
        cyc(0, 0, 0, 1, 1);
        for (int i = 0; i < 40; i++) cyc(1, rnd(), rnd(), 1, 0);
        dec_ratio = CW'(100);
        for (int i = 0; i < 140; i++) cyc(1, rnd(), rnd(), 1, 0);

        do_async_reset();
        dec_ratio = CW'(7);
        shift = SH_W'(5);
        for (int i = 0; i < 60; i++) cyc(1, rnd(), rnd(), 1, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
